// File: rtl/cpu_pkg.sv
// Shared CPU types for the branch-condition interface between the compare unit
// and jump_control. Both sides import this package, so the encodings exist in one place only.
package cpu_pkg;

   typedef enum logic [1:0] {
      GREATER = 2'b00,
      LESS    = 2'b01,
      EQUAL   = 2'b10,
      UNKNOWN = 2'b11
   } result_t;

   typedef enum logic [3:0] {
      BLT = 4'b0100,
      BGT = 4'b0101,
      BE  = 4'b0110,
      JMP = 4'b1100
   } opcode_t;

endpackage

// File: rtl/cmp_classify.sv
// Combinational three-way compare of a against b. It is written to be reusable by the ALU.
// Equality does not depend on is_signed. is_signed selects only the ordering.
module cmp_classify
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              is_signed,
   output result_t           result
);

   logic less_than;

   always_comb begin
      less_than = 1'b0;
      if (is_signed) less_than = ($signed(a) < $signed(b));
      else           less_than = (a < b);
   end

   always_comb begin
      result = GREATER;
      if (a == b)         result = EQUAL;
      else if (less_than) result = LESS;
   end

endmodule

// File: rtl/compare_flag_unit.sv
// Two-stage CMP pipeline in EX. It holds the committed result_t flag that branch decode
// reads, and it stalls a branch while an older compare is still in flight.
module compare_flag_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmp_issue,
   input  logic              cmp_signed,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              flush,
   input  logic              br_query,
   output result_t           cmp_result,
   output logic              flag_valid,
   output logic              stall
);

   // Handshake: cmp_issue has no ready, because one CMP is accepted every cycle.
   // The only back-pressure is stall, which is aimed at the branch in decode. A branch
   // may consume cmp_result only in a cycle where br_query=1 and stall=0.
   logic              s1_valid;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic              s1_signed;
   result_t           s2_class;
   result_t           flag;

   cmp_classify #(.DATA_W(DATA_W)) u_classify (
      .a         (s1_a),
      .b         (s1_b),
      .is_signed (s1_signed),
      .result    (s2_class)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_signed <= 1'b0;
      end else begin
         s1_valid <= cmp_issue & ~flush;
         if (cmp_issue && !flush) begin
            s1_a      <= op_a;
            s1_b      <= op_b;
            s1_signed <= cmp_signed;
         end
      end
   end

   // A flush leaves the already committed flag as it is.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag       <= UNKNOWN;
         flag_valid <= 1'b0;
      end else if (s1_valid && !flush) begin
         flag       <= s2_class;
         flag_valid <= 1'b1;
      end
   end

   assign cmp_result = flag;
   assign stall      = br_query & (cmp_issue | s1_valid) & ~rst;

endmodule
